// File: rtl/ysyx_22050133_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel (AR/R) between instruction fetch (m0)
// and load/store (m1). One whole transaction is granted at a time, from AR handshake to last beat.
module ysyx_22050133_axi_rd_arbiter #(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // m0: instruction fetch
  input  logic                      m0_ar_valid_i,
  output logic                      m0_ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] m0_ar_addr_i,
  input  logic [7:0]                m0_ar_len_i,
  output logic                      m0_r_valid_o,
  input  logic                      m0_r_ready_i,
  output logic [AXI_DATA_WIDTH-1:0] m0_r_data_o,
  output logic                      m0_r_last_o,
  // m1: load/store
  input  logic                      m1_ar_valid_i,
  output logic                      m1_ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] m1_ar_addr_i,
  input  logic [7:0]                m1_ar_len_i,
  output logic                      m1_r_valid_o,
  input  logic                      m1_r_ready_i,
  output logic [AXI_DATA_WIDTH-1:0] m1_r_data_o,
  output logic                      m1_r_last_o,
  // slave side
  output logic                      s_ar_valid_o,
  input  logic                      s_ar_ready_i,
  output logic [AXI_ID_WIDTH-1:0]   s_ar_id_o,
  output logic [AXI_ADDR_WIDTH-1:0] s_ar_addr_o,
  output logic [7:0]                s_ar_len_o,
  input  logic                      s_r_valid_i,
  output logic                      s_r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] s_r_data_i,
  input  logic                      s_r_last_i
);

  localparam logic [AXI_ID_WIDTH-1:0] IdIf  = AXI_ID_WIDTH'(1);
  localparam logic [AXI_ID_WIDTH-1:0] IdMem = '0;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e state_q;
  logic   grant_q;       // 0 = m0, 1 = m1
  logic   last_grant_q;
  logic   winner;
  logic   any_req;
  logic   route_en;
  logic   m0_sel;
  logic   m1_sel;
  logic   last_beat;

  assign any_req = m0_ar_valid_i | m1_ar_valid_i;

  // On a tie the master that was not served last wins.
  always_comb begin
    winner = 1'b0;
    if (m0_ar_valid_i && m1_ar_valid_i) begin
      winner = ~last_grant_q;
    end else if (m1_ar_valid_i) begin
      winner = 1'b1;
    end
  end

  assign m0_ar_ready_o = (state_q == StIdle) & any_req & ~winner;
  assign m1_ar_ready_o = (state_q == StIdle) & any_req & winner;

  // R routing is live in both ADDR and DATA so no beat can slip past unrouted.
  assign route_en = (state_q != StIdle);
  assign m0_sel   = route_en & ~grant_q;
  assign m1_sel   = route_en & grant_q;

  assign m0_r_valid_o = m0_sel & s_r_valid_i;
  assign m0_r_last_o  = m0_sel & s_r_last_i;
  assign m0_r_data_o  = m0_sel ? s_r_data_i : '0;
  assign m1_r_valid_o = m1_sel & s_r_valid_i;
  assign m1_r_last_o  = m1_sel & s_r_last_i;
  assign m1_r_data_o  = m1_sel ? s_r_data_i : '0;
  assign s_r_ready_o  = (m0_sel & m0_r_ready_i) | (m1_sel & m1_r_ready_i);

  assign last_beat = s_r_valid_i & s_r_ready_o & s_r_last_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      s_ar_valid_o <= 1'b0;
      s_ar_addr_o  <= '0;
      s_ar_len_o   <= '0;
      s_ar_id_o    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q      <= winner;
            s_ar_addr_o  <= winner ? m1_ar_addr_i : m0_ar_addr_i;
            s_ar_len_o   <= winner ? m1_ar_len_i : m0_ar_len_i;
            s_ar_id_o    <= winner ? IdMem : IdIf;
            s_ar_valid_o <= 1'b1;
            state_q      <= StAddr;
          end
        end
        StAddr: begin
          if (s_ar_ready_i) begin
            s_ar_valid_o <= 1'b0;
            state_q      <= StData;
          end
        end
        StData: begin
          // Only the slave's last flag ends the transaction; len is not counted.
          if (last_beat) begin
            last_grant_q <= grant_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_axi_rd_arbiter.sv
// Self-checking bench for the two-master AXI read arbiter: directed scenarios plus a
// randomized run checked against a transaction-level round-robin model.
module tb_ysyx_22050133_axi_rd_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_ar_valid_i, m0_ar_ready_o, m0_r_valid_o, m0_r_ready_i, m0_r_last_o;
  logic [31:0] m0_ar_addr_i;
  logic [7:0]  m0_ar_len_i;
  logic [63:0] m0_r_data_o;
  logic        m1_ar_valid_i, m1_ar_ready_o, m1_r_valid_o, m1_r_ready_i, m1_r_last_o;
  logic [31:0] m1_ar_addr_i;
  logic [7:0]  m1_ar_len_i;
  logic [63:0] m1_r_data_o;
  logic        s_ar_valid_o, s_ar_ready_i, s_r_valid_i, s_r_ready_o, s_r_last_i;
  logic [3:0]  s_ar_id_o;
  logic [31:0] s_ar_addr_o;
  logic [7:0]  s_ar_len_o;
  logic [63:0] s_r_data_i;

  int total;
  int passed;

  ysyx_22050133_axi_rd_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .m0_ar_valid_i (m0_ar_valid_i),
    .m0_ar_ready_o (m0_ar_ready_o),
    .m0_ar_addr_i  (m0_ar_addr_i),
    .m0_ar_len_i   (m0_ar_len_i),
    .m0_r_valid_o  (m0_r_valid_o),
    .m0_r_ready_i  (m0_r_ready_i),
    .m0_r_data_o   (m0_r_data_o),
    .m0_r_last_o   (m0_r_last_o),
    .m1_ar_valid_i (m1_ar_valid_i),
    .m1_ar_ready_o (m1_ar_ready_o),
    .m1_ar_addr_i  (m1_ar_addr_i),
    .m1_ar_len_i   (m1_ar_len_i),
    .m1_r_valid_o  (m1_r_valid_o),
    .m1_r_ready_i  (m1_r_ready_i),
    .m1_r_data_o   (m1_r_data_o),
    .m1_r_last_o   (m1_r_last_o),
    .s_ar_valid_o  (s_ar_valid_o),
    .s_ar_ready_i  (s_ar_ready_i),
    .s_ar_id_o     (s_ar_id_o),
    .s_ar_addr_o   (s_ar_addr_o),
    .s_ar_len_o    (s_ar_len_o),
    .s_r_valid_i   (s_r_valid_i),
    .s_r_ready_o   (s_r_ready_o),
    .s_r_data_i    (s_r_data_i),
    .s_r_last_i    (s_r_last_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] beat_data(input logic [31:0] addr, input int idx);
    return {addr, ~addr ^ 32'(idx)};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_ar_valid_i = 0; m0_ar_addr_i = '0; m0_ar_len_i = '0; m0_r_ready_i = 0;
    m1_ar_valid_i = 0; m1_ar_addr_i = '0; m1_ar_len_i = '0; m1_r_ready_i = 0;
    s_ar_ready_i = 0; s_r_valid_i = 0; s_r_data_i = '0; s_r_last_i = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    s_r_valid_i = 1; s_r_data_i = 64'hFFFF_0000_FFFF_0000; s_r_last_i = 1;
    m0_r_ready_i = 1; m1_r_ready_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({s_ar_valid_o, s_ar_id_o, s_ar_addr_o, s_ar_len_o} !== 45'd0)
      $display("FAIL reset_ar: got %h required 0",
               {s_ar_valid_o, s_ar_id_o, s_ar_addr_o, s_ar_len_o});
    else passed++;
    total++;
    if ({s_r_ready_o, m0_r_valid_o, m1_r_valid_o, m0_r_last_o, m1_r_last_o} !== 5'd0 ||
        m0_r_data_o !== '0 || m1_r_data_o !== '0)
      $display("FAIL reset_r_gating: got rdy=%b v0=%b v1=%b l0=%b l1=%b required all 0",
               s_r_ready_o, m0_r_valid_o, m1_r_valid_o, m0_r_last_o, m1_r_last_o);
    else passed++;
    next_cycle();
    rst = 0;
    clear_inputs();
    @(negedge clk);
    total++;
    if ({m0_ar_ready_o, m1_ar_ready_o, s_ar_valid_o} !== 3'b000)
      $display("FAIL reset_no_req: got %b required 000",
               {m0_ar_ready_o, m1_ar_ready_o, s_ar_valid_o});
    else passed++;
    next_cycle();
  endtask

  task automatic test_single_if();
    apply_reset();
    m0_ar_valid_i = 1; m0_ar_addr_i = 32'h8000_0000; m0_ar_len_i = 0;
    @(negedge clk);
    total++;
    if ({m0_ar_ready_o, m1_ar_ready_o, s_ar_valid_o} !== 3'b100)
      $display("FAIL single_ar_ready: got %b required 100",
               {m0_ar_ready_o, m1_ar_ready_o, s_ar_valid_o});
    else passed++;
    next_cycle();
    m0_ar_valid_i = 0; s_ar_ready_i = 1;
    @(negedge clk);
    total++;
    if ({s_ar_valid_o, s_ar_id_o, s_ar_addr_o, s_ar_len_o} !== {1'b1, 4'd1, 32'h8000_0000, 8'd0})
      $display("FAIL single_s_ar: got v=%b id=%h a=%h l=%h required 1 1 80000000 00",
               s_ar_valid_o, s_ar_id_o, s_ar_addr_o, s_ar_len_o);
    else passed++;
    next_cycle();
    s_ar_ready_i = 0; s_r_valid_i = 1; s_r_data_i = 64'h1122_3344_5566_7788; s_r_last_i = 1;
    m0_r_ready_i = 1;
    @(negedge clk);
    total++;
    if (m0_r_valid_o !== 1 || m0_r_data_o !== 64'h1122_3344_5566_7788 || m0_r_last_o !== 1 ||
        s_r_ready_o !== 1 || m1_r_valid_o !== 0 || s_ar_valid_o !== 0)
      $display("FAIL single_r_beat: got v=%b d=%h l=%b rdy=%b v1=%b arv=%b required 1 %h 1 1 0 0",
               m0_r_valid_o, m0_r_data_o, m0_r_last_o, s_r_ready_o, m1_r_valid_o, s_ar_valid_o,
               64'h1122_3344_5566_7788);
    else passed++;
    next_cycle();
    @(negedge clk);
    total++;
    if ({s_r_ready_o, m0_r_valid_o, m0_r_last_o} !== 3'b000)
      $display("FAIL single_back_idle: got %b required 000",
               {s_r_ready_o, m0_r_valid_o, m0_r_last_o});
    else passed++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_both_after_reset();
    apply_reset();
    m0_ar_valid_i = 1; m0_ar_addr_i = 32'h0000_1000;
    m1_ar_valid_i = 1; m1_ar_addr_i = 32'h0000_2000;
    @(negedge clk);
    total++;
    if ({m0_ar_ready_o, m1_ar_ready_o} !== 2'b10)
      $display("FAIL both_first_grant: got %b required 10", {m0_ar_ready_o, m1_ar_ready_o});
    else passed++;
    next_cycle();
    m0_ar_valid_i = 0; s_ar_ready_i = 1;
    @(negedge clk);
    total++;
    if (s_ar_id_o !== 4'd1 || s_ar_addr_o !== 32'h1000 || m1_ar_ready_o !== 0)
      $display("FAIL both_first_ar: got id=%h a=%h r1=%b required 1 00001000 0",
               s_ar_id_o, s_ar_addr_o, m1_ar_ready_o);
    else passed++;
    next_cycle();
    s_ar_ready_i = 0; s_r_valid_i = 1; s_r_last_i = 1; s_r_data_i = 64'h55; m0_r_ready_i = 1;
    @(negedge clk);
    total++;
    if (m1_ar_ready_o !== 0 || m0_r_valid_o !== 1)
      $display("FAIL both_data_phase: got r1=%b v0=%b required 0 1", m1_ar_ready_o, m0_r_valid_o);
    else passed++;
    next_cycle();
    s_r_valid_i = 0; s_r_last_i = 0;
    @(negedge clk);
    total++;
    if ({m0_ar_ready_o, m1_ar_ready_o} !== 2'b01)
      $display("FAIL both_second_grant: got %b required 01", {m0_ar_ready_o, m1_ar_ready_o});
    else passed++;
    next_cycle();
    m1_ar_valid_i = 0; s_ar_ready_i = 1;
    @(negedge clk);
    total++;
    if (s_ar_valid_o !== 1 || s_ar_id_o !== 4'd0 || s_ar_addr_o !== 32'h2000)
      $display("FAIL both_second_ar: got v=%b id=%h a=%h required 1 0 00002000",
               s_ar_valid_o, s_ar_id_o, s_ar_addr_o);
    else passed++;
    next_cycle();
    s_ar_ready_i = 0; s_r_valid_i = 1; s_r_last_i = 1; s_r_data_i = 64'h66; m1_r_ready_i = 1;
    @(negedge clk);
    total++;
    if (m1_r_valid_o !== 1 || m1_r_data_o !== 64'h66 || m0_r_valid_o !== 0)
      $display("FAIL both_second_beat: got v1=%b d1=%h v0=%b required 1 66 0",
               m1_r_valid_o, m1_r_data_o, m0_r_valid_o);
    else passed++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    apply_reset();
    m0_ar_valid_i = 1; m0_ar_addr_i = 32'h100;
    m1_ar_valid_i = 1; m1_ar_addr_i = 32'h200;
    m0_r_ready_i = 1; m1_r_ready_i = 1;
    for (int t = 0; t < 4; t++) begin
      int got;
      got = -1;
      for (int w = 0; w < 10 && got < 0; w++) begin
        @(negedge clk);
        if (m0_ar_ready_o === 1'b1) got = 0;
        else if (m1_ar_ready_o === 1'b1) got = 1;
        next_cycle();
      end
      total++;
      if (got != t % 2) $display("FAIL rr_order_%0d: got master %0d required %0d", t, got, t % 2);
      else passed++;
      s_ar_ready_i = 1;
      @(negedge clk);
      total++;
      if (s_ar_id_o !== ((t % 2 == 0) ? 4'd1 : 4'd0))
        $display("FAIL rr_id_%0d: got %h required %h", t, s_ar_id_o, (t % 2 == 0) ? 1 : 0);
      else passed++;
      next_cycle();
      s_ar_ready_i = 0; s_r_valid_i = 1; s_r_last_i = 1; s_r_data_i = 64'(t);
      next_cycle();
      s_r_valid_i = 0; s_r_last_i = 0;
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    int beat;
    int delivered;
    logic rdy;
    apply_reset();
    m1_ar_valid_i = 1; m1_ar_addr_i = 32'h3000; m1_ar_len_i = 3;
    @(negedge clk);
    total++;
    if ({m0_ar_ready_o, m1_ar_ready_o} !== 2'b01)
      $display("FAIL bp_grant: got %b required 01", {m0_ar_ready_o, m1_ar_ready_o});
    else passed++;
    next_cycle();
    m1_ar_valid_i = 0; s_ar_ready_i = 1;
    @(negedge clk);
    total++;
    if (s_ar_len_o !== 8'd3 || s_ar_id_o !== 4'd0)
      $display("FAIL bp_ar: got len=%h id=%h required 03 0", s_ar_len_o, s_ar_id_o);
    else passed++;
    next_cycle();
    s_ar_ready_i = 0;
    beat = 0; delivered = 0; rdy = 1;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      m1_r_ready_i = rdy; s_r_valid_i = 1;
      s_r_data_i = 64'hA0 + 64'(beat); s_r_last_i = (beat == 3);
      @(negedge clk);
      total++;
      if (s_r_ready_o !== rdy || m1_r_valid_o !== 1 || m1_r_data_o !== 64'hA0 + 64'(beat) ||
          m1_r_last_o !== (beat == 3) || m0_r_valid_o !== 0)
        $display("FAIL bp_beat_%0d: got rdy=%b v=%b d=%h l=%b v0=%b required %b 1 %h %b 0",
                 beat, s_r_ready_o, m1_r_valid_o, m1_r_data_o, m1_r_last_o, m0_r_valid_o,
                 rdy, 64'hA0 + 64'(beat), beat == 3);
      else passed++;
      if (m1_r_valid_o && rdy) delivered++;
      if (s_r_ready_o) beat++;
      rdy = ~rdy;
      next_cycle();
    end
    total++;
    if (delivered != 4) $display("FAIL bp_count: got %0d beats required 4", delivered);
    else passed++;
    s_r_valid_i = 0; s_r_last_i = 0; m1_r_ready_i = 1;
    @(negedge clk);
    total++;
    if ({s_r_ready_o, m1_r_valid_o} !== 2'b00)
      $display("FAIL bp_idle: got %b required 00", {s_r_ready_o, m1_r_valid_o});
    else passed++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_ar_stall();
    apply_reset();
    m0_ar_valid_i = 1; m0_ar_addr_i = 32'h4000_0040; m0_ar_len_i = 2;
    next_cycle();
    m0_ar_valid_i = 0; m0_ar_addr_i = 32'hDEAD_BEEF; m0_ar_len_i = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      s_ar_ready_i = (c == 5);
      @(negedge clk);
      total++;
      if ({s_ar_valid_o, s_ar_id_o, s_ar_addr_o, s_ar_len_o} !==
          {1'b1, 4'd1, 32'h4000_0040, 8'd2})
        $display("FAIL stall_hold_%0d: got v=%b id=%h a=%h l=%h required 1 1 40000040 02",
                 c, s_ar_valid_o, s_ar_id_o, s_ar_addr_o, s_ar_len_o);
      else passed++;
      next_cycle();
    end
    s_ar_ready_i = 0; m0_r_ready_i = 1;
    @(negedge clk);
    total++;
    if ({s_ar_valid_o, s_r_ready_o} !== 2'b01)
      $display("FAIL stall_to_data: got %b required 01", {s_ar_valid_o, s_r_ready_o});
    else passed++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    // A completed m0 transaction leaves m1 as the tie winner unless reset restores priority.
    m0_ar_valid_i = 1; m0_ar_addr_i = 32'h10;
    next_cycle();
    m0_ar_valid_i = 0; s_ar_ready_i = 1;
    next_cycle();
    s_ar_ready_i = 0; s_r_valid_i = 1; s_r_last_i = 1; m0_r_ready_i = 1;
    next_cycle();
    s_r_valid_i = 0; s_r_last_i = 0;
    m1_ar_valid_i = 1; m1_ar_addr_i = 32'h20; m1_ar_len_i = 3;
    next_cycle();
    m1_ar_valid_i = 0; s_ar_ready_i = 1;
    next_cycle();
    s_ar_ready_i = 0; s_r_valid_i = 1; s_r_data_i = 64'hB0; m1_r_ready_i = 1;
    next_cycle();
    s_r_data_i = 64'hB1; rst = 1;
    @(negedge clk);
    total++;
    if (m1_r_valid_o !== 1 || m1_r_data_o !== 64'hB1)
      $display("FAIL rstmid_beat2: got v=%b d=%h required 1 b1", m1_r_valid_o, m1_r_data_o);
    else passed++;
    next_cycle();
    rst = 0; m0_ar_valid_i = 1; m1_ar_valid_i = 1;
    @(negedge clk);
    total++;
    if ({s_ar_valid_o, m0_r_valid_o, m1_r_valid_o, s_r_ready_o} !== 4'b0000)
      $display("FAIL rstmid_idle: got %b required 0000",
               {s_ar_valid_o, m0_r_valid_o, m1_r_valid_o, s_r_ready_o});
    else passed++;
    total++;
    if ({m0_ar_ready_o, m1_ar_ready_o} !== 2'b10)
      $display("FAIL rstmid_priority: got %b required 10", {m0_ar_ready_o, m1_ar_ready_o});
    else passed++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    logic [31:0] ra [2];
    logic [7:0]  rl [2];
    bit          req [2];
    bit          wait_r [2];
    int          bidx [2];
    int          age [2];
    bit          busy, ar_out, hold_v, sdata, stalled;
    int          who, lw, sbeat, win;
    logic [31:0] saddr;
    logic [7:0]  slen;
    logic [1:0]  exp_rdy;
    logic        gv, gr, gl, ov;
    logic [63:0] gd, od;
    apply_reset();
    busy = 0; ar_out = 0; hold_v = 0; sdata = 0; stalled = 0;
    who = 0; lw = 1; sbeat = 0; saddr = '0; slen = '0;
    for (int m = 0; m < 2; m++) begin
      ra[m] = '0; rl[m] = '0; req[m] = 0; wait_r[m] = 0; bidx[m] = 0; age[m] = 0;
    end
    for (int cyc = 0; cyc < 3000 && !stalled; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && !wait_r[m] && $urandom_range(1) == 1) begin
          req[m] = 1; ra[m] = $urandom; rl[m] = 8'($urandom_range(3));
        end
      end
      m0_ar_valid_i = req[0]; m0_ar_addr_i = ra[0]; m0_ar_len_i = rl[0];
      m1_ar_valid_i = req[1]; m1_ar_addr_i = ra[1]; m1_ar_len_i = rl[1];
      m0_r_ready_i = 1'($urandom_range(1));
      m1_r_ready_i = 1'($urandom_range(1));
      s_ar_ready_i = 1'($urandom_range(1));
      s_r_valid_i  = sdata && (hold_v || $urandom_range(2) != 0);
      s_r_data_i   = beat_data(saddr, sbeat);
      s_r_last_i   = sdata && (sbeat == int'(slen));
      @(negedge clk);
      if (busy) begin
        gv = who ? m1_r_valid_o : m0_r_valid_o;
        gd = who ? m1_r_data_o : m0_r_data_o;
        gl = who ? m1_r_last_o : m0_r_last_o;
        gr = who ? m1_r_ready_i : m0_r_ready_i;
        ov = who ? m0_r_valid_o : m1_r_valid_o;
        od = who ? m0_r_data_o : m1_r_data_o;
        total++;
        if (s_r_ready_o !== gr || gv !== s_r_valid_i || ov !== 1'b0 || od !== '0)
          $display("FAIL rnd_route c%0d: got rdy=%b v=%b other_v=%b other_d=%h required %b %b 0 0",
                   cyc, s_r_ready_o, gv, ov, od, gr, s_r_valid_i);
        else passed++;
        if (s_r_valid_i) begin
          total++;
          if (gd !== beat_data(ra[who], bidx[who]) || gl !== (bidx[who] == int'(rl[who])))
            $display("FAIL rnd_beat c%0d m%0d: got d=%h l=%b required %h %b", cyc, who, gd, gl,
                     beat_data(ra[who], bidx[who]), bidx[who] == int'(rl[who]));
          else passed++;
        end
      end else begin
        total++;
        if ({s_r_ready_o, m0_r_valid_o, m1_r_valid_o} !== 3'b000)
          $display("FAIL rnd_idle_r c%0d: got %b required 000", cyc,
                   {s_r_ready_o, m0_r_valid_o, m1_r_valid_o});
        else passed++;
      end
      total++;
      if (ar_out) begin
        if ({s_ar_valid_o, s_ar_id_o, s_ar_addr_o, s_ar_len_o} !==
            {1'b1, (who == 0) ? 4'd1 : 4'd0, ra[who], rl[who]})
          $display("FAIL rnd_ar c%0d: got v=%b id=%h a=%h l=%h required 1 %0d %h %h", cyc,
                   s_ar_valid_o, s_ar_id_o, s_ar_addr_o, s_ar_len_o, (who == 0) ? 1 : 0,
                   ra[who], rl[who]);
        else passed++;
      end else begin
        if (s_ar_valid_o !== 1'b0)
          $display("FAIL rnd_ar_idle c%0d: got v=%b required 0", cyc, s_ar_valid_o);
        else passed++;
      end
      exp_rdy = 2'b00; win = -1;
      if (!busy && (req[0] || req[1])) begin
        if (req[0] && req[1]) win = (lw == 0) ? 1 : 0;
        else win = req[0] ? 0 : 1;
        exp_rdy = (win == 0) ? 2'b01 : 2'b10;
      end
      total++;
      if ({m1_ar_ready_o, m0_ar_ready_o} !== exp_rdy)
        $display("FAIL rnd_grant c%0d: got {r1,r0}=%b required %b", cyc,
                 {m1_ar_ready_o, m0_ar_ready_o}, exp_rdy);
      else passed++;
      // Advance the model to match what the coming clock edge commits.
      if (busy && s_r_valid_i && s_r_ready_o) begin
        hold_v = 0;
        if (s_r_last_i) begin
          busy = 0; wait_r[who] = 0; sdata = 0;
        end
        bidx[who]++;
        sbeat++;
      end else begin
        hold_v = s_r_valid_i;
      end
      if (ar_out && s_ar_ready_i) begin
        ar_out = 0; sdata = 1; sbeat = 0; saddr = s_ar_addr_o; slen = s_ar_len_o; hold_v = 0;
      end
      if (win >= 0) begin
        busy = 1; ar_out = 1; who = win; lw = win;
        req[win] = 0; wait_r[win] = 1; bidx[win] = 0;
      end
      for (int m = 0; m < 2; m++) begin
        age[m] = (req[m] || wait_r[m]) ? age[m] + 1 : 0;
        if (age[m] > 200) stalled = 1;
      end
      next_cycle();
    end
    total++;
    if (stalled) $display("FAIL rnd_progress: got a master waiting over 200 cycles required none");
    else passed++;
    clear_inputs();
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_single_if();
    test_both_after_reset();
    test_round_robin();
    test_backpressure();
    test_ar_stall();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ysyx_22050133_axi_rd_arbiter.md
Name: ysyx_22050133_axi_rd_arbiter

Overview:
- Shares the single AXI4 read channel (AR/R) of the memory slave between two masters: instruction fetch (m0, IF) and load/store (m1, MEM).
- Grants one complete transaction at a time, address handshake through the last R beat; round-robin priority between the masters.
- Tags requests with an AXI ID: 1 for IF, 0 for MEM. The slave uses the ID to choose its instruction or data read path.
- Write channels do not pass through this block; MEM connects to the slave AW/W/B directly. The top level ties ar_size=3'b011 and ar_burst=2'b01 (INCR).

Parameters:
AXI_DATA_WIDTH, 64, R data width
AXI_ADDR_WIDTH, 32, AR address width
AXI_ID_WIDTH, 4, AR ID width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
m0_ar_valid_i  in  1  IF read request
m0_ar_ready_o  out  1  IF request accepted
m0_ar_addr_i  in  ADDR  IF address
m0_ar_len_i  in  8  IF burst length-1
m0_r_valid_o  out  1  IF read data valid
m0_r_ready_i  in  1  IF ready for data
m0_r_data_o  out  DATA  IF read data
m0_r_last_o  out  1  IF last beat
m1_ar_valid_i, m1_ar_ready_o, m1_ar_addr_i, m1_ar_len_i, m1_r_valid_o, m1_r_ready_i, m1_r_data_o, m1_r_last_o: same directions, widths and meanings as the m0 ports, for MEM
s_ar_valid_o  out  1  request to slave
s_ar_ready_i  in  1  slave accepts address
s_ar_id_o  out  ID  1 = IF, 0 = MEM
s_ar_addr_o  out  ADDR  latched address
s_ar_len_o  out  8  latched length
s_r_valid_i  in  1  slave data valid
s_r_ready_o  out  1  ready to slave
s_r_data_i  in  DATA  slave data
s_r_last_i  in  1  slave last beat

Behaviour:
- States: IDLE, ADDR, DATA. Registers: grant (0 = m0, 1 = m1), last_grant, and the latched s_ar_addr/len/id.
- Reset values: state = IDLE, last_grant = 1 (so m0 wins the first tie), grant = 0, s_ar_valid_o = 0, s_ar_addr_o/len/id = 0.
- Outputs combinationally 0 while in IDLE: s_r_ready_o, every m*_r_valid_o, every m*_r_last_o.
- Reset mid-transaction aborts to IDLE with the reset values above; the slave is reset by the same rst.

IDLE:
- Winner selection is combinational. Only one ar_valid high: that master wins. Both high: the master != last_grant wins.
- m{winner}_ar_ready_o = 1 in the same cycle as the request (combinational, IDLE only). The loser's ar_ready_o stays 0.
- On the accepting edge: latch winner addr/len, set s_ar_id_o = (winner==m0 ? 1 : 0), set grant = winner, set s_ar_valid_o = 1, go to ADDR.
- s_ar_valid_o therefore rises 1 cycle after the master handshake.
- No request: stay in IDLE.

ADDR:
- Hold s_ar_valid_o and the latched fields stable until s_ar_ready_i = 1.
- On that edge: s_ar_valid_o <= 0, go to DATA.
- All m*_ar_ready_o = 0.

DATA (routing also active in ADDR):
- Combinational routing to the granted master only: m{grant}_r_valid_o = s_r_valid_i, m{grant}_r_data_o = s_r_data_i, m{grant}_r_last_o = s_r_last_i, s_r_ready_o = m{grant}_r_ready_i.
- Non-granted master: r_valid_o = 0, r_last_o = 0, r_data_o = 0.
- Backpressure passes through with zero added latency; beats are never dropped or duplicated.
- A beat with s_r_valid_i & s_r_ready_o & s_r_last_i ends the transaction: last_grant <= grant, go to IDLE.
- A new grant is possible in the cycle after the last beat (1 idle turnaround cycle minimum).

Rules:
- A master that keeps ar_valid high while the other holds the grant waits; its address must stay stable (AXI rule, not checked here).
- Transaction end is determined by s_r_last_i only. len is forwarded but not counted.
- m*_ar_ready_o is never 1 outside IDLE, so a request arriving during ADDR/DATA is accepted at the earliest in the first IDLE cycle.

Test Plan:
1. m0 alone, addr 0x80000000, len 0; slave ar_ready=1, one R beat 0x1122334455667788 -> m0_ar_ready high same cycle; s_ar_valid next cycle with id 1, addr 0x80000000; m0 receives data with last=1; m1_r_valid stays 0; back in IDLE 1 cycle after the beat.
2. m0 and m1 both valid in the same cycle right after reset -> m0 served first (id 1); m1 granted in the first IDLE cycle after m0's last beat, with s_ar_id_o=0.
3. Both masters hold ar_valid continuously for 4 transactions -> grant order m0, m1, m0, m1.
4. m1 burst len 3, m1_r_ready toggling 1,0,1,0... -> s_r_ready_o mirrors it; 4 beats 0xA0..0xA3 delivered in order; r_last only on the 4th beat.
5. s_ar_ready_i held low 5 cycles -> s_ar_valid_o and addr/len/id stable for all 5 cycles; handshake on cycle 6; state enters DATA.
6. rst asserted during beat 2 of a len-3 burst -> next cycle state IDLE, s_ar_valid_o=0, both r_valid_o=0; first request after reset goes to m0.
